// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg : HI/LO unit op encodings, FSM states and decode helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_core.sv
// ---------------------------------------------------------------------------
// muldiv_core : combinational 64-bit multiply / divide result for HI/LO
// Config: MDU_DIV0_HOLD_EN -> divide by zero flags res_keep (HI/LO untouched)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_core
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_keep
);

  logic        sgn;
  logic        div0;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign sgn  = md_is_signed(op);
  assign div0 = (rt == 32'd0);

  // Sign-extending to 64 bits makes the low 64 bits of the product exact for signed ops
  assign a64  = {{32{sgn & rs[31]}}, rs};
  assign b64  = {{32{sgn & rt[31]}}, rt};
  assign prod = a64 * b64;

  // Signed divide on magnitudes: quotient truncates toward zero and the remainder
  // follows the dividend; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_mag  = (sgn & rs[31]) ? (32'd0 - rs) : rs;
  assign b_mag  = (sgn & rt[31]) ? (32'd0 - rt) : rt;
  assign b_safe = div0 ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (sgn & (rs[31] ^ rt[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem    = (sgn & rs[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (md_is_div(op)) begin
      if (div0) begin
        res_hi = rs;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

`ifdef MDU_DIV0_HOLD_EN
  assign res_keep = md_is_div(op) & div0;
`else
  assign res_keep = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl : E-stage HI/LO sequencer with fixed-latency busy and D-stall
// Config: MDU_DIV0_HOLD_EN (divide by zero keeps HI/LO, see muldiv_core)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        e_cancel,
  input  logic        d_md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        start,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_keep_q, pend_keep_d;

  logic        valid;
  logic [31:0] core_hi;
  logic [31:0] core_lo;
  logic        core_keep;

  muldiv_core u_core (
    .op       (e_md_op),
    .rs       (e_rs),
    .rt       (e_rt),
    .res_hi   (core_hi),
    .res_lo   (core_lo),
    .res_keep (core_keep)
  );

  assign busy     = (state_q == ST_BUSY);
  assign valid    = (e_md_op >= MD_MULT) && (e_md_op <= MD_MTLO) && !e_cancel && !busy;
  assign start    = valid && md_is_arith(e_md_op);
  assign md_stall = d_md_use && (start || busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_keep_d = pend_keep_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_BUSY;
          cnt_d       = md_is_div(e_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d   = core_hi;
          pend_lo_d   = core_lo;
          pend_keep_d = core_keep;
        end else if (valid && (e_md_op == MD_MTHI)) begin
          hi_d = e_rs;
        end else if (valid && (e_md_op == MD_MTLO)) begin
          lo_d = e_rs;
        end
      end
      ST_BUSY: begin
        // Last busy cycle: commit the result held since the start edge
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!pend_keep_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_keep_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_keep_q <= pend_keep_d;
    end
  end

endmodule

`default_nettype wire
